// File: rtl/clock_pkg.sv
// Shared types, BCD limits and the field validity check for the time-of-day block.
package clock_pkg;

  typedef logic [7:0] bcd2_t;

  localparam bcd2_t BCD_MAX_SEC  = 8'h59;
  localparam bcd2_t BCD_MAX_MIN  = 8'h59;
  localparam bcd2_t BCD_MAX_HOUR = 8'h23;

  typedef enum logic {
    IDLE    = 1'b0,
    RINGING = 1'b1
  } alarm_state_t;

  // Both digits must be decimal; comparing raw BCD bytes orders them like decimals.
  function automatic logic bcd2_valid(bcd2_t v, bcd2_t max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter wrapping MAX -> 00 with a carry out; a load overrides the increment.
module bcd2_counter
  import clock_pkg::*;
#(
  parameter bcd2_t MAX = 8'h59
) (
  input  logic  clk,
  input  logic  reset_sync,
  input  logic  inc,
  input  logic  load,
  input  bcd2_t load_val,
  output bcd2_t val,
  output bcd2_t next_val,
  output logic  carry
);

  // next_val is what val becomes on an increment, so the top can match the post-tick time.
  always_comb begin
    next_val = val;
    carry    = 1'b0;
    if (inc) begin
      if (val == MAX) begin
        next_val = 8'h00;
        carry    = 1'b1;
      end else if (val[3:0] == 4'd9) begin
        next_val = {val[7:4] + 4'd1, 4'h0};
      end else begin
        next_val = {val[7:4], val[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_sync) begin
      val <= 8'h00;
    end else if (load) begin
      val <= load_val;
    end else begin
      val <= next_val;
    end
  end

endmodule

// File: rtl/time_of_day_counter.sv
// BCD hh:mm:ss time of day with a set-time load handshake and an hh:mm alarm that rings
// for a bounded number of seconds.
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter int ALARM_HOLD_SEC = 60
) (
  input  logic         clk,
  input  logic         reset_sync,
  input  logic         sec_tick,
  input  logic         set_valid,
  input  bcd2_t        set_hh,
  input  bcd2_t        set_mm,
  input  bcd2_t        set_ss,
  output logic         set_ready,
  output logic         set_err,
  input  logic         alarm_en,
  input  bcd2_t        alarm_hh,
  input  bcd2_t        alarm_mm,
  output bcd2_t        hh,
  output bcd2_t        mm,
  output bcd2_t        ss,
  output logic         min_tick,
  output logic         alarm_ring,
  output alarm_state_t alarm_state
);

  localparam logic [7:0] HOLD = 8'(ALARM_HOLD_SEC);

  // Handshake: a load transfers on a rising edge where set_valid && set_ready. Good fields
  // are taken and set_ready drops for one cycle; bad fields are refused with a one-cycle
  // set_err and set_ready stays high. While set_ready is low set_valid is ignored.
  logic  busy;
  logic  fields_ok, load_acc, load_rej, tick_eff;
  logic  ss_carry, mm_carry, hh_carry;
  bcd2_t ss_next, mm_next, hh_next;
  logic  unused_bits;

  assign set_ready = ~busy;
  assign fields_ok = bcd2_valid(set_hh, BCD_MAX_HOUR) &&
                     bcd2_valid(set_mm, BCD_MAX_MIN)  &&
                     bcd2_valid(set_ss, BCD_MAX_SEC);
  assign load_acc  = set_valid & set_ready & fields_ok;
  assign load_rej  = set_valid & set_ready & ~fields_ok;
  // An accepted load swallows a coincident tick.
  assign tick_eff  = sec_tick & ~load_acc;

  bcd2_counter #(.MAX(BCD_MAX_SEC)) u_ss (
    .clk(clk), .reset_sync(reset_sync), .inc(tick_eff), .load(load_acc),
    .load_val(set_ss), .val(ss), .next_val(ss_next), .carry(ss_carry)
  );
  bcd2_counter #(.MAX(BCD_MAX_MIN)) u_mm (
    .clk(clk), .reset_sync(reset_sync), .inc(ss_carry), .load(load_acc),
    .load_val(set_mm), .val(mm), .next_val(mm_next), .carry(mm_carry)
  );
  bcd2_counter #(.MAX(BCD_MAX_HOUR)) u_hh (
    .clk(clk), .reset_sync(reset_sync), .inc(mm_carry), .load(load_acc),
    .load_val(set_hh), .val(hh), .next_val(hh_next), .carry(hh_carry)
  );

  assign unused_bits = ^{ss_next, hh_carry};

  always_ff @(posedge clk) begin
    if (reset_sync) begin
      busy     <= 1'b0;
      set_err  <= 1'b0;
      min_tick <= 1'b0;
    end else begin
      busy     <= load_acc;
      set_err  <= load_rej;
      min_tick <= ss_carry;
    end
  end

  // Alarm FSM. The match uses the post-tick hh:mm, so only a tick into hh:mm:00 fires it.
  alarm_state_t state, state_n;
  logic [7:0]   hold_cnt, hold_cnt_n, hold_sat;
  logic         alarm_hit;

  assign alarm_hit   = alarm_en & ss_carry & (hh_next == alarm_hh) & (mm_next == alarm_mm);
  assign hold_sat    = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
  assign alarm_ring  = (state == RINGING);
  assign alarm_state = state;

  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    case (state)
      IDLE: begin
        if (alarm_hit) begin
          state_n    = RINGING;
          hold_cnt_n = 8'd0;
        end
      end
      RINGING: begin
        if (!alarm_en) begin
          state_n = IDLE;
        end else if (sec_tick) begin
          hold_cnt_n = hold_sat;
          if (hold_sat >= HOLD) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_sync) begin
      state    <= IDLE;
      hold_cnt <= 8'd0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_cnt_n;
    end
  end

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter: directed scenarios plus random traffic, checked every cycle
// against a seconds-of-day reference model.
module tb_time_of_day_counter;
  import clock_pkg::*;

  localparam int HOLD_SEC = 60;

  logic         clk = 1'b0;
  logic         reset_sync = 1'b1;
  logic         sec_tick = 1'b0;
  logic         set_valid = 1'b0;
  logic [7:0]   set_hh = 8'h00, set_mm = 8'h00, set_ss = 8'h00;
  logic         set_ready, set_err;
  logic         alarm_en = 1'b0;
  logic [7:0]   alarm_hh = 8'h00, alarm_mm = 8'h00;
  logic [7:0]   hh, mm, ss;
  logic         min_tick, alarm_ring;
  alarm_state_t alarm_state;

  int total = 0;
  int bad   = 0;

  time_of_day_counter #(.ALARM_HOLD_SEC(HOLD_SEC)) dut (
    .clk(clk), .reset_sync(reset_sync), .sec_tick(sec_tick),
    .set_valid(set_valid), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .set_ready(set_ready), .set_err(set_err),
    .alarm_en(alarm_en), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
    .hh(hh), .mm(mm), .ss(ss), .min_tick(min_tick),
    .alarm_ring(alarm_ring), .alarm_state(alarm_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: time as seconds since midnight ----------------
  int m_sec  = 0;
  bit m_busy = 0, m_err = 0, m_min = 0, m_ring = 0;
  int m_hold = 0;

  function automatic logic [7:0] to_bcd(int n);
    logic [3:0] hi, lo;
    hi = 4'(n / 10);
    lo = 4'(n % 10);
    return {hi, lo};
  endfunction

  function automatic bit field_ok(logic [7:0] v, int max_dec);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return 0;
    return (int'(v[7:4]) * 10 + int'(v[3:0])) <= max_dec;
  endfunction

  function automatic int dec(logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  task automatic model_step();
    bit ok, acc, rej, trig;
    int prev;
    if (reset_sync) begin
      m_sec = 0; m_busy = 0; m_err = 0; m_min = 0; m_ring = 0; m_hold = 0;
      return;
    end
    ok   = field_ok(set_hh, 23) && field_ok(set_mm, 59) && field_ok(set_ss, 59);
    acc  = set_valid && !m_busy && ok;
    rej  = set_valid && !m_busy && !ok;
    trig = 0;
    m_min = 0;
    if (acc) begin
      m_sec = dec(set_hh) * 3600 + dec(set_mm) * 60 + dec(set_ss);
    end else if (sec_tick) begin
      prev  = m_sec;
      m_sec = (m_sec + 1) % 86400;
      m_min = (prev % 60 == 59);
      trig  = m_min && alarm_en && to_bcd(m_sec / 3600) == alarm_hh &&
              to_bcd((m_sec / 60) % 60) == alarm_mm;
    end
    if (m_ring) begin
      if (!alarm_en) m_ring = 0;
      else if (sec_tick) begin
        m_hold = (m_hold < 255) ? m_hold + 1 : 255;
        if (m_hold >= HOLD_SEC) m_ring = 0;
      end
    end else if (trig) begin
      m_ring = 1;
      m_hold = 0;
    end
    m_busy = acc;
    m_err  = rej;
  endtask

  // ---------------- checking ----------------
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    check("hh",         32'(hh),          32'(to_bcd(m_sec / 3600)));
    check("mm",         32'(mm),          32'(to_bcd((m_sec / 60) % 60)));
    check("ss",         32'(ss),          32'(to_bcd(m_sec % 60)));
    check("min_tick",   32'(min_tick),    32'(m_min));
    check("set_err",    32'(set_err),     32'(m_err));
    check("set_ready",  32'(set_ready),   32'(!m_busy));
    check("alarm_ring", 32'(alarm_ring),  32'(m_ring));
    check("state_dbg",  32'(alarm_state), 32'(m_ring));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    sec_tick  = 1'b0;
    set_valid = 1'b0;
    reset_sync = 1'b0;
  endtask

  task automatic do_reset();
    reset_sync = 1'b1;
    cycle();
  endtask

  task automatic do_load(logic [7:0] h, logic [7:0] m, logic [7:0] s, bit with_tick);
    set_hh = h; set_mm = m; set_ss = s;
    set_valid = 1'b1;
    sec_tick  = with_tick;
    cycle();
    cycle();
  endtask

  task automatic do_ticks(int n);
    for (int i = 0; i < n; i++) begin
      sec_tick = 1'b1;
      cycle();
      if ($urandom_range(0, 1) == 1) cycle();
    end
  endtask

  initial begin
    // clock/reset
    reset_sync = 1'b1;
    cycle();
    cycle();
    check("reset_hh", 32'(hh), 32'h00);
    check("reset_ready", 32'(set_ready), 32'h1);

    // rollover: min_tick only on the second tick
    do_load(8'h23, 8'h59, 8'h58, 0);
    sec_tick = 1'b1; cycle();
    check("roll_1_min", 32'(min_tick), 32'h0);
    sec_tick = 1'b1; cycle();
    check("roll_2_hms", 32'({hh, mm, ss}), 32'h000000);
    check("roll_2_min", 32'(min_tick), 32'h1);
    cycle();

    // digit carries
    do_load(8'h09, 8'h09, 8'h09, 0);
    do_ticks(1);
    check("carry_a", 32'({hh, mm, ss}), 32'h090910);
    do_load(8'h09, 8'h59, 8'h59, 0);
    do_ticks(1);
    check("carry_b", 32'({hh, mm, ss}), 32'h100000);

    // invalid loads, the second colliding with a tick
    set_hh = 8'h24; set_mm = 8'h00; set_ss = 8'h00; set_valid = 1'b1; cycle();
    check("bad_hh_err", 32'(set_err), 32'h1);
    cycle();
    set_hh = 8'h12; set_ss = 8'h5A; set_valid = 1'b1; sec_tick = 1'b1; cycle();
    check("bad_ss_err", 32'(set_err), 32'h1);
    check("bad_ss_time", 32'({hh, mm, ss}), 32'h100001);
    cycle();

    // load collides with tick
    do_load(8'h05, 8'h00, 8'h00, 1);
    check("collide", 32'({hh, mm, ss}), 32'h050000);

    // alarm rings, runs out after HOLD_SEC ticks
    alarm_en = 1'b1; alarm_hh = 8'h06; alarm_mm = 8'h30;
    do_load(8'h06, 8'h29, 8'h59, 0);
    sec_tick = 1'b1; cycle();
    check("alarm_on", 32'(alarm_ring), 32'h1);
    do_ticks(HOLD_SEC);
    check("alarm_timeout", 32'(alarm_ring), 32'h0);

    // cancel by alarm_en
    do_load(8'h06, 8'h29, 8'h59, 0);
    do_ticks(3);
    alarm_en = 1'b0; cycle();
    check("alarm_cancel", 32'(alarm_ring), 32'h0);
    alarm_en = 1'b1;

    // loading straight onto the alarm time does not ring
    do_load(8'h06, 8'h30, 8'h00, 0);
    check("alarm_by_load", 32'(alarm_ring), 32'h0);

    // reset while ringing at 12:34:56
    alarm_hh = 8'h12; alarm_mm = 8'h34;
    do_load(8'h12, 8'h33, 8'h59, 0);
    for (int i = 0; i < 57; i++) begin sec_tick = 1'b1; cycle(); end
    check("pre_reset_hms", 32'({hh, mm, ss}), 32'h123456);
    check("pre_reset_ring", 32'(alarm_ring), 32'h1);
    do_reset();
    check("post_reset_hms", 32'({hh, mm, ss}), 32'h000000);
    check("post_reset_ring", 32'(alarm_ring), 32'h0);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      sec_tick = ($urandom_range(0, 2) == 0);
      alarm_en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 24) == 0) begin
        set_valid = 1'b1;
        if ($urandom_range(0, 3) != 0) begin
          int h, m;
          h = $urandom_range(0, 23);
          m = $urandom_range(0, 59);
          set_hh = to_bcd(h); set_mm = to_bcd(m);
          set_ss = to_bcd($urandom_range(50, 59));
          if ($urandom_range(0, 1) == 1) begin
            alarm_hh = to_bcd((m == 59) ? (h + 1) % 24 : h);
            alarm_mm = to_bcd((m + 1) % 60);
          end
        end else begin
          set_hh = 8'($urandom); set_mm = 8'($urandom); set_ss = 8'($urandom);
        end
      end
      reset_sync = ($urandom_range(0, 999) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
